hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the five-stage RV32E core (ID, EX, MEMPREP, MEMEX, WB). It decides each cycle which stages hold, which receive bubbles and which are flushed. It covers three cases the operand forwarding path cannot resolve:
- load-use hazards, where load data is only forwardable from WB;
- control redirects resolved in EX;
- multi-cycle EX operations.

It also keeps stall and flush performance counters.

## Interface
Parameters:
- FLUSH_CYCLES, default 2: cycles IF/ID are flushed per redirect; legal 1..7.
- PERF_WIDTH, default 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs1_ID, rs2_ID  in  4  source register indices of the instruction in ID.
- rs1_used_ID, rs2_used_ID  in  1  the ID instruction actually reads rs1 / rs2.
- regfile_we_EX, regfile_we_MEMPREP, regfile_we_MEMEX  in  1  the stage's instruction writes rd.
- rd_EX, rd_MEMPREP, rd_MEMEX  in  4  destination index per stage.
- mem_load_EX, mem_load_MEMPREP, mem_load_MEMEX  in  1  the stage's rd data comes from memory (load).
- redirect_EX  in  1  branch/jump in EX taken (PC redirect).
- mc_start_EX  in  1  the EX instruction needs the multi-cycle unit.
- mc_done  in  1  multi-cycle unit result valid this cycle.
- stall_IF, stall_ID, stall_EX  out  1  hold the pipeline register feeding that stage.
- bubble_EX, bubble_MEMPREP  out  1  load a NOP into that stage's input register.
- flush_IF, flush_ID  out  1  kill the instruction in that stage.
- state  out  2  0 = RUN, 1 = MC_WAIT, 2 = FLUSH.
- stall_count, flush_count  out  PERF_WIDTH  performance counters.

## Operation
- **Load-use detect (combinational).** For each used source rs, where rs != 0:
  - Find the nearest stage (EX, then MEMPREP, then MEMEX) with regfile_we=1 and rd == rs.
  - The hazard fires only if that stage's mem_load=1. A nearer non-load writer masks an older load.
  - rd == 0 never matches.
- **RUN:**
  - mc_start_EX=1 and mc_done=0: stall_IF = stall_ID = stall_EX = 1, bubble_MEMPREP = 1; next state MC_WAIT.
  - mc_start_EX=1 and mc_done=1 in the same cycle: no stall, stay RUN.
  - Otherwise, redirect_EX=1: flush_IF = flush_ID = 1, bubble_EX = 1, flush_count += 1, counter ← FLUSH_CYCLES-1. Next state is FLUSH if the counter > 0, else RUN.
  - Otherwise, load-use hazard: stall_IF = stall_ID = 1, bubble_EX = 1.
- **MC_WAIT:**
  - While mc_done=0: stall_IF/ID/EX = 1, bubble_MEMPREP = 1.
  - On mc_done=1: all stall outputs 0 that cycle; next state RUN.
  - redirect_EX is ignored while stall_EX=1. The instruction stays in EX, so the redirect is acted on in the cycle EX advances, following the RUN rules in that same cycle.
  - A load-use hazard is not evaluated separately in this state; the ID stall already covers it.
- **FLUSH:**
  - flush_IF = flush_ID = 1 every cycle; the counter decrements; return to RUN in the cycle after the counter reaches 0.
  - Load-use stalls are suppressed (ID is being killed).
  - redirect_EX=1 restarts the sequence (counter ← FLUSH_CYCLES-1, flush_count += 1).
  - mc_start_EX cannot be legal here (EX holds bubbles); the bench asserts it is 0.
- **Priority** within one cycle: multi-cycle stall > redirect > load-use.
- **Counters:**
  - stall_count += 1 every cycle stall_ID=1.
  - flush_count += 1 per accepted redirect.
  - Both wrap modulo 2^PERF_WIDTH.

## Timing
- **Reset:**
  - state = RUN, internal counter = 0, stall_count = flush_count = 0.
  - While rst=1, every combinational output is forced to 0.
  - Asserting rst in MC_WAIT or FLUSH returns to RUN immediately, without waiting for a clock edge.
- Load-use stall: zero-cycle decision latency (same cycle as the ID instruction is present).
  - Load in EX: 3 stall cycles.
  - Load in MEMPREP: 2 stall cycles.
  - Load in MEMEX: 1 stall cycle.
  - The instruction leaves ID once the load reaches WB.
- Redirect: flush asserted for exactly FLUSH_CYCLES consecutive cycles, starting in the redirect cycle.
- Multi-cycle: stalls span the cycle mc_start_EX rises through the cycle before mc_done. An N-cycle operation (mc_done in the N-th cycle) yields N-1 stall cycles.
- Outputs are combinational from state, counter and inputs; no output is registered except state and the counters.

## Test plan
- **Load-use, EX.** Load with rd=5 in EX (mem_load_EX=1), ID rs1=5 used, pipeline advancing each cycle.
  - Required: stall_ID=1 and bubble_EX=1 for 3 cycles, then 0; stall_count=3.
- **Masked hazard.** ALU write rd=5 in EX, load rd=5 in MEMPREP, ID rs2=5.
  - Required: no stall.
  - Same setup with rs=0 and rd=0 load: no stall.
- **Redirect.** FLUSH_CYCLES=3, redirect_EX pulse.
  - Required: flush_IF/ID high for exactly 3 cycles, state sequence RUN→FLUSH→FLUSH→RUN, flush_count=1.
- **Multi-cycle op.** mc_start_EX held, mc_done in the 4th cycle.
  - Required: stall_EX=1 and bubble_MEMPREP=1 for 3 cycles, state 1 then 0.
  - mc_done in the same cycle as mc_start: zero stalls.
- **Simultaneous events.** mc_start_EX and redirect_EX together, mc_done in the 3rd cycle.
  - Required: no flush before the 3rd cycle; flush begins in the 3rd cycle.
  - Concurrent load-use hazard in ID: absorbed, no extra stall.
- **Reset mid-operation.** rst asserted asynchronously mid-FLUSH and mid-MC_WAIT.
  - Required: outputs 0 immediately, state=0, counters 0; normal operation after release.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline sequencing controller for the five-stage RV32E core
// (ID, EX, MEMPREP, MEMEX, WB). Each cycle it decides which stages hold,
// which receive bubbles and which are flushed, covering load-use hazards,
// EX-resolved control redirects and multi-cycle EX operations. It also
// keeps stall and flush performance counters.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   rs1_ID/rs2_ID, *_used_ID    source registers of the ID instruction
//   regfile_we_*, rd_*          destination writer info for EX/MEMPREP/MEMEX
//   mem_load_*                  that stage's rd value comes from memory
//   redirect_EX                 taken branch/jump resolved in EX
//   mc_start_EX, mc_done        multi-cycle unit request / result valid
//   stall_IF/ID/EX              hold the register feeding that stage
//   bubble_EX/MEMPREP           insert a NOP into that stage
//   flush_IF/ID                 kill the instruction in that stage
//   state                       0 = RUN, 1 = MC_WAIT, 2 = FLUSH
//   stall_count, flush_count    wrapping performance counters
module hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            rs1_ID,
    input  logic [3:0]            rs2_ID,
    input  logic                  rs1_used_ID,
    input  logic                  rs2_used_ID,
    input  logic                  regfile_we_EX,
    input  logic                  regfile_we_MEMPREP,
    input  logic                  regfile_we_MEMEX,
    input  logic [3:0]            rd_EX,
    input  logic [3:0]            rd_MEMPREP,
    input  logic [3:0]            rd_MEMEX,
    input  logic                  mem_load_EX,
    input  logic                  mem_load_MEMPREP,
    input  logic                  mem_load_MEMEX,
    input  logic                  redirect_EX,
    input  logic                  mc_start_EX,
    input  logic                  mc_done,
    output logic                  stall_IF,
    output logic                  stall_ID,
    output logic                  stall_EX,
    output logic                  bubble_EX,
    output logic                  bubble_MEMPREP,
    output logic                  flush_IF,
    output logic                  flush_ID,
    output logic [1:0]            state,
    output logic [PERF_WIDTH-1:0] stall_count,
    output logic [PERF_WIDTH-1:0] flush_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MC_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    // Remaining flush cycles after the redirect cycle itself.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [2:0] cnt_reg;
    logic [2:0] cnt_next;
    logic       redirect_take;

    // ------------------------------------------------------------------
    // Load-use detection, one slice per source operand. The nearest
    // writer wins: a younger ALU result for the same rd masks an older
    // load, since that value is forwardable.
    // ------------------------------------------------------------------
    logic [1:0][3:0] rs_id;
    logic [1:0]      rs_used;
    logic [1:0]      src_hazard;
    logic            load_use;

    assign rs_id   = {rs2_ID, rs1_ID};
    assign rs_used = {rs2_used_ID, rs1_used_ID};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic match_ex;
            logic match_mp;
            logic match_me;
            logic nearest_is_load;

            assign match_ex = regfile_we_EX      && (rd_EX      == rs_id[gi]);
            assign match_mp = regfile_we_MEMPREP && (rd_MEMPREP == rs_id[gi]);
            assign match_me = regfile_we_MEMEX   && (rd_MEMEX   == rs_id[gi]);

            assign nearest_is_load = match_ex ? mem_load_EX :
                                     match_mp ? mem_load_MEMPREP :
                                     match_me ? mem_load_MEMEX : 1'b0;

            // x0 is hard-wired; rs != 0 also excludes every rd == 0 match.
            assign src_hazard[gi] = rs_used[gi] && (rs_id[gi] != 4'd0) && nearest_is_load;
        end
    endgenerate

    assign load_use = |src_hazard;

    // ------------------------------------------------------------------
    // Sequencing decisions
    // ------------------------------------------------------------------
    always_comb begin
        stall_IF       = 1'b0;
        stall_ID       = 1'b0;
        stall_EX       = 1'b0;
        bubble_EX      = 1'b0;
        bubble_MEMPREP = 1'b0;
        flush_IF       = 1'b0;
        flush_ID       = 1'b0;
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        redirect_take  = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (mc_start_EX && !mc_done) begin
                    stall_IF       = 1'b1;
                    stall_ID       = 1'b1;
                    stall_EX       = 1'b1;
                    bubble_MEMPREP = 1'b1;
                    state_next     = ST_MC_WAIT;
                end else if (redirect_EX) begin
                    redirect_take = 1'b1;
                end else if (load_use) begin
                    stall_IF  = 1'b1;
                    stall_ID  = 1'b1;
                    bubble_EX = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                if (!mc_done) begin
                    stall_IF       = 1'b1;
                    stall_ID       = 1'b1;
                    stall_EX       = 1'b1;
                    bubble_MEMPREP = 1'b1;
                end else begin
                    // EX advances now, so a redirect held in EX is acted on
                    // this very cycle. Any load-use is already resolved by
                    // the long ID stall.
                    state_next    = ST_RUN;
                    redirect_take = redirect_EX;
                end
            end
            ST_FLUSH: begin
                flush_IF = 1'b1;
                flush_ID = 1'b1;
                if (redirect_EX) begin
                    redirect_take = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                    if (cnt_reg <= 3'd1) begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (redirect_take) begin
            flush_IF   = 1'b1;
            flush_ID   = 1'b1;
            bubble_EX  = 1'b1;
            cnt_next   = FLUSH_RELOAD;
            state_next = (FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end

        // Nothing is asserted toward the pipeline while reset is held.
        if (rst) begin
            stall_IF       = 1'b0;
            stall_ID       = 1'b0;
            stall_EX       = 1'b0;
            bubble_EX      = 1'b0;
            bubble_MEMPREP = 1'b0;
            flush_IF       = 1'b0;
            flush_ID       = 1'b0;
            redirect_take  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, flush counter and performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= 3'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (stall_ID) begin
                stall_count <= stall_count + PERF_WIDTH'(1);
            end
            if (redirect_take) begin
                flush_count <= flush_count + PERF_WIDTH'(1);
            end
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
// Self-checking bench for hazard_controller (FLUSH_CYCLES = 3,
// PERF_WIDTH = 8). Directed scenario tasks plus a randomized run checked
// against a cycle-level behavioural model of the sequencing rules.
module tb_hazard_controller;

    localparam int F  = 3;
    localparam int PW = 8;

    // Control vector order: {stall_IF, stall_ID, stall_EX, bubble_EX,
    //                        bubble_MEMPREP, flush_IF, flush_ID}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1101000;
    localparam logic [6:0] C_MC   = 7'b1110100;
    localparam logic [6:0] C_FRD  = 7'b0001011;
    localparam logic [6:0] C_FO   = 7'b0000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] rs1_ID, rs2_ID, rd_EX, rd_MEMPREP, rd_MEMEX;
    logic rs1_used_ID, rs2_used_ID;
    logic regfile_we_EX, regfile_we_MEMPREP, regfile_we_MEMEX;
    logic mem_load_EX, mem_load_MEMPREP, mem_load_MEMEX;
    logic redirect_EX, mc_start_EX, mc_done;
    logic stall_IF, stall_ID, stall_EX, bubble_EX, bubble_MEMPREP, flush_IF, flush_ID;
    logic [1:0] state;
    logic [PW-1:0] stall_count, flush_count;
    logic [6:0] ctl;

    int n_cmp = 0;
    int n_bad = 0;

    assign ctl = {stall_IF, stall_ID, stall_EX, bubble_EX, bubble_MEMPREP, flush_IF, flush_ID};

    always #5 clk = ~clk;

    hazard_controller #(.FLUSH_CYCLES(F), .PERF_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .regfile_we_EX(regfile_we_EX), .regfile_we_MEMPREP(regfile_we_MEMPREP),
        .regfile_we_MEMEX(regfile_we_MEMEX),
        .rd_EX(rd_EX), .rd_MEMPREP(rd_MEMPREP), .rd_MEMEX(rd_MEMEX),
        .mem_load_EX(mem_load_EX), .mem_load_MEMPREP(mem_load_MEMPREP),
        .mem_load_MEMEX(mem_load_MEMEX),
        .redirect_EX(redirect_EX), .mc_start_EX(mc_start_EX), .mc_done(mc_done),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
        .bubble_EX(bubble_EX), .bubble_MEMPREP(bubble_MEMPREP),
        .flush_IF(flush_IF), .flush_ID(flush_ID),
        .state(state), .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic idle_inputs();
        rs1_ID = 4'd0; rs2_ID = 4'd0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
        regfile_we_EX = 1'b0; regfile_we_MEMPREP = 1'b0; regfile_we_MEMEX = 1'b0;
        rd_EX = 4'd0; rd_MEMPREP = 4'd0; rd_MEMEX = 4'd0;
        mem_load_EX = 1'b0; mem_load_MEMPREP = 1'b0; mem_load_MEMEX = 1'b0;
        redirect_EX = 1'b0; mc_start_EX = 1'b0; mc_done = 1'b0;
    endtask

    task automatic clear_stages();
        regfile_we_EX = 1'b0; regfile_we_MEMPREP = 1'b0; regfile_we_MEMEX = 1'b0;
        mem_load_EX = 1'b0; mem_load_MEMPREP = 1'b0; mem_load_MEMEX = 1'b0;
        rd_EX = 4'd0; rd_MEMPREP = 4'd0; rd_MEMEX = 4'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Behavioural load-use rule: the nearest writer of rs decides.
    function automatic bit luse(input logic [3:0] rs, input logic used);
        bit         we [3];
        logic [3:0] rd [3];
        bit         ld [3];
        we = '{regfile_we_EX, regfile_we_MEMPREP, regfile_we_MEMEX};
        rd = '{rd_EX, rd_MEMPREP, rd_MEMEX};
        ld = '{mem_load_EX, mem_load_MEMPREP, mem_load_MEMEX};
        if (!used || rs == 4'd0) return 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (we[i] && rd[i] == rs) return ld[i];
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        rs1_ID = 4'd5; rs1_used_ID = 1'b1; regfile_we_EX = 1'b1; rd_EX = 4'd5; mem_load_EX = 1'b1;
        redirect_EX = 1'b1; mc_start_EX = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (stall_count !== 8'd0 || flush_count !== 8'd0) begin
            n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_count, flush_count); end
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        logic [6:0] exp;
        do_reset();
        rs1_ID = 4'd5; rs1_used_ID = 1'b1;
        for (int c = 0; c < 4; c++) begin
            clear_stages();
            case (c)
                0: begin regfile_we_EX = 1'b1;      rd_EX = 4'd5;      mem_load_EX = 1'b1;      end
                1: begin regfile_we_MEMPREP = 1'b1; rd_MEMPREP = 4'd5; mem_load_MEMPREP = 1'b1; end
                2: begin regfile_we_MEMEX = 1'b1;   rd_MEMEX = 4'd5;   mem_load_MEMEX = 1'b1;   end
                default: ;
            endcase
            exp = (c < 3) ? C_LU : C_NONE;
            @(negedge clk);
            n_cmp++; if (ctl !== exp) begin n_bad++; $display("FAIL load_use_c%0d: got %b want %b", c, ctl, exp); end
            next_cycle();
        end
        n_cmp++; if (stall_count !== 8'd3) begin n_bad++; $display("FAIL load_use_count: got %0d want 3", stall_count); end
        $display("test_load_use done");
    endtask

    task automatic test_masked();
        do_reset();
        // ALU writer in EX masks the older load in MEMPREP
        regfile_we_EX = 1'b1; rd_EX = 4'd5;
        regfile_we_MEMPREP = 1'b1; rd_MEMPREP = 4'd5; mem_load_MEMPREP = 1'b1;
        rs2_ID = 4'd5; rs2_used_ID = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL masked_alu: got %b want %b", ctl, C_NONE); end
        next_cycle();
        // x0 source against a rd=0 load
        idle_inputs();
        rs1_ID = 4'd0; rs1_used_ID = 1'b1; regfile_we_EX = 1'b1; rd_EX = 4'd0; mem_load_EX = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL masked_x0: got %b want %b", ctl, C_NONE); end
        next_cycle();
        // unused source does not stall
        idle_inputs();
        rs1_ID = 4'd5; regfile_we_EX = 1'b1; rd_EX = 4'd5; mem_load_EX = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL masked_unused: got %b want %b", ctl, C_NONE); end
        next_cycle();
        // different-rd ALU writer does not mask a MEMEX load
        idle_inputs();
        rs2_ID = 4'd9; rs2_used_ID = 1'b1; regfile_we_EX = 1'b1; rd_EX = 4'd3;
        regfile_we_MEMEX = 1'b1; rd_MEMEX = 4'd9; mem_load_MEMEX = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctl !== C_LU) begin n_bad++; $display("FAIL unmasked_memex: got %b want %b", ctl, C_LU); end
        next_cycle();
        idle_inputs();
        n_cmp++; if (stall_count !== 8'd1) begin n_bad++; $display("FAIL masked_count: got %0d want 1", stall_count); end
        $display("test_masked done");
    endtask

    task automatic test_redirect();
        logic [6:0] exp_c [4];
        logic [1:0] exp_s [4];
        exp_c = '{C_FRD, C_FO, C_FO, C_NONE};
        exp_s = '{2'd0, 2'd2, 2'd2, 2'd0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            redirect_EX = (c == 0);
            if (c == 1) begin   // load-use in ID is suppressed while flushing
                rs1_ID = 4'd4; rs1_used_ID = 1'b1; regfile_we_EX = 1'b1; rd_EX = 4'd4; mem_load_EX = 1'b1;
            end
            @(negedge clk);
            n_cmp++; if (ctl !== exp_c[c]) begin n_bad++; $display("FAIL redirect_ctl_c%0d: got %b want %b", c, ctl, exp_c[c]); end
            n_cmp++; if (state !== exp_s[c]) begin n_bad++; $display("FAIL redirect_state_c%0d: got %0d want %0d", c, state, exp_s[c]); end
            next_cycle();
        end
        n_cmp++; if (flush_count !== 8'd1 || stall_count !== 8'd0) begin
            n_bad++; $display("FAIL redirect_counts: got flush %0d stall %0d want 1/0", flush_count, stall_count); end
        $display("test_redirect done");
    endtask

    task automatic test_multicycle();
        do_reset();
        mc_start_EX = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            mc_done = (c == 4);
            @(negedge clk);
            n_cmp++; if (ctl !== ((c < 4) ? C_MC : C_NONE)) begin
                n_bad++; $display("FAIL mc_ctl_c%0d: got %b want %b", c, ctl, (c < 4) ? C_MC : C_NONE); end
            n_cmp++; if (state !== ((c == 1) ? 2'd0 : 2'd1)) begin
                n_bad++; $display("FAIL mc_state_c%0d: got %0d want %0d", c, state, (c == 1) ? 0 : 1); end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mc_return: got %0d want 0", state); end
        n_cmp++; if (stall_count !== 8'd3) begin n_bad++; $display("FAIL mc_count: got %0d want 3", stall_count); end
        next_cycle();
        // single-cycle completion: no stall at all
        mc_start_EX = 1'b1; mc_done = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL mc_same_cycle: got %b want %b", ctl, C_NONE); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (state !== 2'd0 || stall_count !== 8'd3) begin
            n_bad++; $display("FAIL mc_same_after: got state %0d stalls %0d want 0/3", state, stall_count); end
        next_cycle();
        $display("test_multicycle done");
    endtask

    task automatic test_simultaneous();
        logic [6:0] exp_c [6];
        logic [1:0] exp_s [6];
        exp_c = '{C_MC, C_MC, C_FRD, C_FO, C_FO, C_LU};
        exp_s = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        do_reset();
        // concurrent load-use hazard held throughout
        rs1_ID = 4'd7; rs1_used_ID = 1'b1; regfile_we_MEMPREP = 1'b1; rd_MEMPREP = 4'd7; mem_load_MEMPREP = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mc_start_EX = (c < 3);
            redirect_EX = (c < 3);
            mc_done     = (c == 2);
            @(negedge clk);
            n_cmp++; if (ctl !== exp_c[c]) begin n_bad++; $display("FAIL simul_ctl_c%0d: got %b want %b", c, ctl, exp_c[c]); end
            n_cmp++; if (state !== exp_s[c]) begin n_bad++; $display("FAIL simul_state_c%0d: got %0d want %0d", c, state, exp_s[c]); end
            if (c == 5) begin
                n_cmp++; if (stall_count !== 8'd2 || flush_count !== 8'd1) begin
                    n_bad++; $display("FAIL simul_counts: got stall %0d flush %0d want 2/1", stall_count, flush_count); end
            end
            next_cycle();
        end
        idle_inputs();
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        redirect_EX = 1'b1;
        next_cycle();
        redirect_EX = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL rmid_in_flush: got %0d want 2", state); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_NONE || state !== 2'd0) begin
            n_bad++; $display("FAIL rmid_flush_async: got ctl %b state %0d want 0/0", ctl, state); end
        n_cmp++; if (flush_count !== 8'd0) begin n_bad++; $display("FAIL rmid_flush_count: got %0d want 0", flush_count); end
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ctl !== C_NONE || state !== 2'd0) begin
            n_bad++; $display("FAIL rmid_flush_after: got ctl %b state %0d want 0/0", ctl, state); end
        next_cycle();
        mc_start_EX = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (state !== 2'd1 || ctl !== C_MC) begin
            n_bad++; $display("FAIL rmid_in_mc: got ctl %b state %0d want %b/1", ctl, state, C_MC); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_NONE || state !== 2'd0 || stall_count !== 8'd0) begin
            n_bad++; $display("FAIL rmid_mc_async: got ctl %b state %0d stalls %0d want 0/0/0", ctl, state, stall_count); end
        mc_start_EX = 1'b0;
        rst = 1'b0;
        next_cycle();
        rs1_ID = 4'd2; rs1_used_ID = 1'b1; regfile_we_EX = 1'b1; rd_EX = 4'd2; mem_load_EX = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctl !== C_LU || state !== 2'd0) begin
            n_bad++; $display("FAIL rmid_normal: got ctl %b state %0d want %b/0", ctl, state, C_LU); end
        next_cycle();
        idle_inputs();
        $display("test_reset_mid done");
    endtask

    task automatic test_counter_wrap();
        do_reset();
        rs1_ID = 4'd1; rs1_used_ID = 1'b1; regfile_we_EX = 1'b1; rd_EX = 4'd1; mem_load_EX = 1'b1;
        repeat (258) next_cycle();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (stall_count !== 8'd2) begin n_bad++; $display("FAIL counter_wrap: got %0d want 2", stall_count); end
        next_cycle();
        $display("test_counter_wrap done");
    endtask

    task automatic test_random();
        bit         mc_busy;
        int         flush_left;
        logic [7:0] exp_sc, exp_fc;
        logic [6:0] exp_c;
        logic [1:0] exp_s;
        bit         lu;
        int         bad_before;
        do_reset();
        mc_busy = 1'b0; flush_left = 0; exp_sc = 8'd0; exp_fc = 8'd0;
        bad_before = n_bad;
        for (int i = 0; i < 600; i++) begin
            rs1_ID = 4'($urandom_range(0, 3)); rs2_ID = 4'($urandom_range(0, 3));
            rs1_used_ID = 1'($urandom); rs2_used_ID = 1'($urandom);
            regfile_we_EX = 1'($urandom); regfile_we_MEMPREP = 1'($urandom); regfile_we_MEMEX = 1'($urandom);
            rd_EX = 4'($urandom_range(0, 3)); rd_MEMPREP = 4'($urandom_range(0, 3)); rd_MEMEX = 4'($urandom_range(0, 3));
            mem_load_EX = 1'($urandom); mem_load_MEMPREP = 1'($urandom); mem_load_MEMEX = 1'($urandom);
            redirect_EX = ($urandom_range(0, 7) == 0);
            mc_start_EX = ($urandom_range(0, 5) == 0);
            mc_done     = ($urandom_range(0, 2) == 0);
            if (flush_left > 0 && !mc_busy) mc_start_EX = 1'b0;   // EX holds bubbles while flushing

            lu    = luse(rs1_ID, rs1_used_ID) || luse(rs2_ID, rs2_used_ID);
            exp_s = mc_busy ? 2'd1 : ((flush_left > 0) ? 2'd2 : 2'd0);
            exp_c = C_NONE;
            @(negedge clk);
            n_cmp++; if (stall_count !== exp_sc || flush_count !== exp_fc) begin
                n_bad++; $display("FAIL rand_counts_%0d: got %0d/%0d want %0d/%0d", i, stall_count, flush_count, exp_sc, exp_fc); end

            if (mc_busy) begin
                if (!mc_done) exp_c = C_MC;
                else begin
                    mc_busy = 1'b0;
                    if (redirect_EX) begin exp_c = C_FRD; exp_fc++; flush_left = F - 1; end
                end
            end else if (flush_left > 0) begin
                if (redirect_EX) begin exp_c = C_FRD; exp_fc++; flush_left = F - 1; end
                else begin exp_c = C_FO; flush_left--; end
            end else begin
                if (mc_start_EX && !mc_done) begin exp_c = C_MC; mc_busy = 1'b1; end
                else if (redirect_EX) begin exp_c = C_FRD; exp_fc++; flush_left = F - 1; end
                else if (lu) exp_c = C_LU;
            end
            if (exp_c[5]) exp_sc++;

            n_cmp++; if (ctl !== exp_c) begin n_bad++; $display("FAIL rand_ctl_%0d: got %b want %b", i, ctl, exp_c); end
            n_cmp++; if (state !== exp_s) begin n_bad++; $display("FAIL rand_state_%0d: got %0d want %0d", i, state, exp_s); end
            next_cycle();
            if (n_bad - bad_before > 20) break;
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_masked();
        test_redirect();
        test_multicycle();
        test_simultaneous();
        test_reset_mid();
        test_counter_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
